// File: rtl/image_processing_top.sv
`default_nettype none
// ============================================================================
//  Module   : image_processing_top
//  Purpose  : Streaming 3x3 valid-mode convolution. Nine 8-bit coefficients
//             are loaded first, then raster-order 8-bit pixels are streamed.
//             Each complete window produces floor(sum(k*p)/9), saturated to
//             16 bits, two cycles after the completing pixel is accepted.
//  Ports    : clk, rst_n                      - clock, async active-low reset
//             kernel_data_in[7:0], _valid/_ready - coefficient handshake
//             data_in[7:0], data_in_valid, ready_for_data_in - pixel handshake
//             processed_data_out[15:0], processed_data_valid - result stream
//  Revision : 1.0 - initial release
// ============================================================================
module image_processing_top #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  kernel_data_in,
  input  logic        kernel_data_in_valid,
  output logic        kernel_data_in_ready,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  output logic        ready_for_data_in,
  output logic [15:0] processed_data_out,
  output logic        processed_data_valid
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [0:0]    S_LOAD_KERNEL = 1'b0;
  localparam logic [0:0]    S_STREAM      = 1'b1;
  localparam logic [CW-1:0] C_COL_LAST    = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] C_ROW_LAST    = RW'(IMG_HEIGHT - 1);

  // Control state
  logic [0:0]    state_q, state_d;
  logic [3:0]    kcnt_q, kcnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          v0_q, v1_q, v2_q;
  logic [15:0]   out_q;

  // Datapath storage (no reset needed)
  logic [7:0]    kern_q  [9];
  logic [7:0]    win_q   [9];   // index = row*3 + col, row 0 = oldest line, col 0 = oldest column
  logic [15:0]   prod_q  [9];
  logic [7:0]    lb0_mem [IMG_WIDTH];  // previous row
  logic [7:0]    lb1_mem [IMG_WIDTH];  // row before that

  logic          w_k_acc;
  logic          w_p_acc;
  logic          w_win_done;
  logic [7:0]    w_lb0_rd;
  logic [7:0]    w_lb1_rd;
  logic [15:0]   w_prod  [9];
  logic [19:0]   w_sum;
  logic [19:0]   w_quot;
  logic [15:0]   w_sat;

  assign w_k_acc  = (state_q == S_LOAD_KERNEL) && kernel_data_in_valid;
  assign w_p_acc  = (state_q == S_STREAM) && data_in_valid;
  assign w_lb0_rd = lb0_mem[col_q];
  assign w_lb1_rd = lb1_mem[col_q];

  // A window is complete only once two full rows and two columns of the
  // current row precede it; this also keeps windows from wrapping rows.
  assign w_win_done = w_p_acc && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Next-state logic: coefficient counter, state, and raster position.
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    col_d   = col_q;
    row_d   = row_q;
    if (w_k_acc) begin
      kcnt_d = kcnt_q + 4'd1;
      if (kcnt_q == 4'd8) begin
        state_d = S_STREAM;
      end
    end
    if (w_p_acc) begin
      if (col_q == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_q == C_ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_mult
      assign w_prod[gi] = 16'(win_q[gi]) * 16'(kern_q[gi]);
    end
  endgenerate

  // Max sum is 9*255*255 = 585225, which needs all 20 bits.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + 20'(prod_q[i]);
    end
  end

  assign w_quot = w_sum / 20'd9;
  assign w_sat  = (|w_quot[19:16]) ? 16'hFFFF : w_quot[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD_KERNEL;
      kcnt_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      v0_q    <= w_win_done;
      v1_q    <= v0_q;
      v2_q    <= v1_q;
      if (v1_q) begin
        out_q <= w_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_k_acc) begin
      for (int i = 0; i < 9; i++) begin
        if (kcnt_q == 4'(i)) begin
          kern_q[i] <= kernel_data_in;
        end
      end
    end
    if (w_p_acc) begin
      lb0_mem[col_q] <= data_in;
      lb1_mem[col_q] <= w_lb0_rd;
      for (int r = 0; r < 3; r++) begin
        win_q[r*3]     <= win_q[r*3 + 1];
        win_q[r*3 + 1] <= win_q[r*3 + 2];
      end
      // New column enters on the right: oldest line on top.
      win_q[2] <= w_lb1_rd;
      win_q[5] <= w_lb0_rd;
      win_q[8] <= data_in;
    end
    // Products are captured only for windows that produce an output, so a
    // stall after the completing pixel cannot disturb the in-flight result.
    if (v0_q) begin
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= w_prod[i];
      end
    end
  end

  assign kernel_data_in_ready = (state_q == S_LOAD_KERNEL);
  assign ready_for_data_in    = (state_q == S_STREAM);
  assign processed_data_out   = out_q;
  assign processed_data_valid = v2_q;

endmodule
`default_nettype wire

// File: tb/tb_image_processing_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_image_processing_top
//  Purpose  : Directed self-checking bench for image_processing_top on a
//             small 6x5 image so whole frames can be checked element by
//             element against a direct 2D convolution model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_image_processing_top;

  localparam int W    = 6;
  localparam int H    = 5;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - 2) * (H - 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  kernel_data_in = '0;
  logic        kernel_data_in_valid = 1'b0;
  logic        kernel_data_in_ready;
  logic [7:0]  data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        ready_for_data_in;
  logic [15:0] processed_data_out;
  logic        processed_data_valid;

  image_processing_top #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .kernel_data_in       (kernel_data_in),
    .kernel_data_in_valid (kernel_data_in_valid),
    .kernel_data_in_ready (kernel_data_in_ready),
    .data_in              (data_in),
    .data_in_valid        (data_in_valid),
    .ready_for_data_in    (ready_for_data_in),
    .processed_data_out   (processed_data_out),
    .processed_data_valid (processed_data_valid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] got[$];
  int unsigned got_cyc[$];
  always @(negedge clk) begin
    if (processed_data_valid) begin
      got.push_back(processed_data_out);
      got_cyc.push_back(cyc);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int kern[9];
  int fr[H][W];
  logic [15:0] exp_q[$];
  logic [15:0] gold[$];
  int unsigned acc_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 16'hxxxx;
  endfunction

  task automatic set_kernel(input int a0, input int a1, input int a2, input int a3,
                            input int a4, input int a5, input int a6, input int a7,
                            input int a8);
    kern = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       fr[r][c] = 90;
          1:       fr[r][c] = (r * 37 + c * 53 + 11) & 255;
          2:       fr[r][c] = ((r + c) * 30) & 255;
          3:       fr[r][c] = 255;
          default: fr[r][c] = (r * 91 + c * 29 + 7) & 255;
        endcase
  endtask

  // Direct convolution over every full window, raster order of bottom-right pixel.
  task automatic build_exp();
    int s, q;
    exp_q.delete();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += kern[i*3 + j] * fr[r-2+i][c-2+j];
        q = s / 9;
        if (q > 65535) q = 65535;
        exp_q.push_back(16'(q));
      end
  endtask

  task automatic load_kernel(input bit toggle);
    for (int i = 0; i < 9; i++) begin
      if (toggle) begin
        kernel_data_in       = 8'hEE;
        kernel_data_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == 8) begin
        check("rdy_pix_before_9th", {31'd0, ready_for_data_in}, 32'd0);
        check("rdy_kern_before_9th", {31'd0, kernel_data_in_ready}, 32'd1);
      end
      kernel_data_in       = 8'(kern[i]);
      kernel_data_in_valid = 1'b1;
      @(posedge clk); #1;
      kernel_data_in_valid = 1'b0;
    end
    check("rdy_pix_after_9th", {31'd0, ready_for_data_in}, 32'd1);
    check("rdy_kern_after_9th", {31'd0, kernel_data_in_ready}, 32'd0);
  endtask

  task automatic send_frame(input bit gaps, input int stop_after);
    int idle;
    for (int idx = 0; idx < NPIX && idx <= stop_after; idx++) begin
      idle = 0;
      while (gaps && ($urandom_range(0, 1) == 1) && idle < 8) begin
        data_in       = 8'($urandom);
        data_in_valid = 1'b0;
        idle++;
        @(posedge clk); #1;
      end
      data_in       = 8'(fr[idx / W][idx % W]);
      data_in_valid = 1'b1;
      @(posedge clk); #1;
      data_in_valid = 1'b0;
      if (idx == 2 * W + 2) acc_first = cyc;
    end
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    build_exp();
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, {16'd0, got_at(i)}, {16'd0, exp_q[i]});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_kern_ready", {31'd0, kernel_data_in_ready}, 32'd1);
    check("rst_pix_ready", {31'd0, ready_for_data_in}, 32'd0);
    check("rst_out", {16'd0, processed_data_out}, 32'd0);
    check("rst_valid", {31'd0, processed_data_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got.delete();
    got_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_kern_ready", {31'd0, kernel_data_in_ready}, 32'd1);
    check("reset_pix_ready", {31'd0, ready_for_data_in}, 32'd0);
    check("reset_out", {16'd0, processed_data_out}, 32'd0);
    check("reset_valid", {31'd0, processed_data_valid}, 32'd0);
    rst_n = 1'b1;

    // Box kernel, constant 90; stray pixel valids during the toggled load must be ignored
    set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
    data_in       = 8'hFF;
    data_in_valid = 1'b1;
    load_kernel(1'b1);
    data_in_valid = 1'b0;
    fill(0);
    send_frame(1'b0, NPIX);
    drain();
    check("box90_count", got.size(), NOUT);
    for (int i = 0; i < NOUT; i++)
      check("box90_val", {16'd0, got_at(i)}, 32'h005A);
    check("box90_latency", (got_cyc.size() > 0) ? got_cyc[0] : 0, acc_first + 2);
    got.delete();
    got_cyc.delete();

    // Second frame reuses the kernel; coefficient valid held high must be ignored
    kernel_data_in       = 8'd200;
    kernel_data_in_valid = 1'b1;
    fill(1);
    send_frame(1'b0, NPIX);
    drain();
    check("stream_kern_ready", {31'd0, kernel_data_in_ready}, 32'd0);
    kernel_data_in_valid = 1'b0;
    compare_model("frame2_reuse");
    got.delete();
    got_cyc.delete();

    // Centre-only kernel on a ramp
    do_reset();
    set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    load_kernel(1'b0);
    fill(2);
    send_frame(1'b0, NPIX);
    drain();
    check("ramp_first", {16'd0, got_at(0)}, 32'd6);      // centre (1,1)=60, 60/9=6
    check("ramp_last", {16'd0, got_at(NOUT - 1)}, 32'd23); // centre (3,4)=210, 210/9=23
    compare_model("ramp");

    // Full-scale: no truncation, 585225/9 = 65025
    do_reset();
    set_kernel(255, 255, 255, 255, 255, 255, 255, 255, 255);
    load_kernel(1'b0);
    fill(3);
    send_frame(1'b0, NPIX);
    drain();
    check("max_count", got.size(), NOUT);
    for (int i = 0; i < NOUT; i++)
      check("max_val", {16'd0, got_at(i)}, 32'hFE01);

    // Gapless vs random-gap run of the same frame
    do_reset();
    set_kernel(1, 2, 3, 4, 5, 6, 7, 8, 9);
    load_kernel(1'b0);
    fill(1);
    send_frame(1'b0, NPIX);
    drain();
    compare_model("gapless");
    gold = got;
    got.delete();
    got_cyc.delete();
    send_frame(1'b1, NPIX);
    drain();
    check("gaps_count", got.size(), gold.size());
    for (int i = 0; i < gold.size(); i++)
      check("gaps_vs_gapless", {16'd0, got_at(i)}, {16'd0, gold[i]});

    // Reset mid-frame with results in flight, then reload and run a fresh frame
    got.delete();
    got_cyc.delete();
    send_frame(1'b0, 2 * W + 3);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_valid", got.size(), 0);
    set_kernel(9, 8, 7, 6, 5, 4, 3, 2, 1);
    load_kernel(1'b1);
    fill(4);
    send_frame(1'b0, NPIX);
    drain();
    compare_model("after_midframe_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
